// File: rtl/gate_tester_if.sv
// Bundle between the gate tester and its environment: run control, the
// gate-under-test pins (X, Y driven by the tester, F returned) and the run result.
interface gate_tester_if #(
  parameter int ERR_W = 3
) ();
  logic             start;
  logic             X;
  logic             Y;
  logic             F;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;

  modport master (
    input  start, F,
    output X, Y, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, F,
    input  X, Y, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_tester.sv
// Walks a 2-input gate through {X,Y} = 00,01,10,11, lets each vector settle,
// samples F once per vector against EXPECT_TABLE and reports the mismatches.
module gate_tester #(
  parameter logic [3:0] EXPECT_TABLE  = 4'b1000,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         ERR_W         = 3
) (
  input  logic         clk,
  input  logic         rst,
  gate_tester_if.master bus
);

  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;
  logic             launch;
  logic             mismatch;

  // Case inequality so an X/Z on F is scored as a failing vector.
  assign mismatch = (bus.F !== EXPECT_TABLE[vec]);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    launch    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          launch    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        state_nxt = (vec == 2'd3) ? DONE : WAIT;
      end
      DONE: begin
        if (bus.start) begin
          launch    = 1'b1;
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        vec       <= '0;
        cnt       <= '0;
        err_count <= '0;
        fail_vec  <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end else if (state == SAMPLE) begin
        if (mismatch) begin
          if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
          fail_vec[vec] <= 1'b1;
        end
        // The last vector stays applied, so X,Y read 11 once the run is over.
        if (vec != 2'd3) begin
          vec <= vec + 1'b1;
          cnt <= '0;
        end
      end
    end
  end

  // X,Y are the vector register itself, so they are registered and hold between runs.
  assign bus.X         = vec[1];
  assign bus.Y         = vec[0];
  assign bus.busy      = (state == WAIT) || (state == SAMPLE);
  assign bus.done      = (state == DONE);
  assign bus.pass      = (state == DONE) && (err_count == '0);
  assign bus.err_count = err_count;
  assign bus.fail_vec  = fail_vec;

endmodule

// File: tb/tb_gate_tester.sv
// Randomized bench for gate_tester: two instances (AND table / settle 2 and
// XOR table / settle 1) driven against truth-table gate models on F.
module tb_gate_tester;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic sel;
  logic [3:0] gate_tt_a;
  logic [3:0] gate_tt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gate_tester_if #(.ERR_W(3)) bus_a ();
  gate_tester_if #(.ERR_W(3)) bus_b ();

  gate_tester #(.EXPECT_TABLE(4'b1000), .SETTLE_CYCLES(2), .ERR_W(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  gate_tester #(.EXPECT_TABLE(4'b0110), .SETTLE_CYCLES(1), .ERR_W(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Gate under test: a truth table indexed by {X,Y}.
  assign bus_a.F     = gate_tt_a[{bus_a.X, bus_a.Y}];
  assign bus_b.F     = gate_tt_b[{bus_b.X, bus_b.Y}];
  assign bus_a.start = start & ~sel;
  assign bus_b.start = start & sel;

  logic       o_x, o_y, o_busy, o_done, o_pass;
  logic [2:0] o_err;
  logic [3:0] o_fail;

  always_comb begin
    if (sel) begin
      o_x = bus_b.X; o_y = bus_b.Y; o_busy = bus_b.busy; o_done = bus_b.done;
      o_pass = bus_b.pass; o_err = bus_b.err_count; o_fail = bus_b.fail_vec;
    end else begin
      o_x = bus_a.X; o_y = bus_a.Y; o_busy = bus_a.busy; o_done = bus_a.done;
      o_pass = bus_a.pass; o_err = bus_a.err_count; o_fail = bus_a.fail_vec;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (dut %0d) got=%0h exp=%0h at %0t", tag, sel, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"},    32'(o_x),    0);
    check({tag, "_y"},    32'(o_y),    0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_pass"}, 32'(o_pass), 0);
    check({tag, "_err"},  32'(o_err),  0);
    check({tag, "_fail"}, 32'(o_fail), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run of the selected DUT against gate truth table tt. Expected
  // results come straight from comparing tt with the DUT's expectation table.
  task automatic run_check(input logic [3:0] tt, input bit noisy);
    int         s;
    int         n;
    int         errs;
    logic [3:0] exp_tbl;
    logic [3:0] diff;
    s       = sel ? 1 : 2;
    n       = 4 * (s + 1);
    exp_tbl = sel ? 4'b0110 : 4'b1000;
    if (sel) gate_tt_b = tt; else gate_tt_a = tt;
    diff    = tt ^ exp_tbl;
    errs    = $countones(diff);
    if (errs > 7) errs = 7;

    repeat ($urandom_range(0, 2)) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("launch_busy", 32'(o_busy), 1);
    check("launch_done", 32'(o_done), 0);
    check("launch_pass", 32'(o_pass), 0);
    check("launch_xy",   32'({o_x, o_y}), 0);
    check("launch_err",  32'(o_err), 0);
    check("launch_fail", 32'(o_fail), 0);

    for (int e = 1; e <= n; e++) begin
      if (noisy && e < n) start = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      if (e < n) begin
        check("run_xy",   32'({o_x, o_y}), 32'(e / (s + 1)));
        check("run_busy", 32'(o_busy), 1);
        check("run_done", 32'(o_done), 0);
      end else begin
        check("end_done", 32'(o_done), 1);
        check("end_busy", 32'(o_busy), 0);
        check("end_pass", 32'(o_pass), 32'(errs == 0));
        check("end_err",  32'(o_err), 32'(errs));
        check("end_fail", 32'(o_fail), 32'(diff));
        check("end_xy",   32'({o_x, o_y}), 3);
      end
    end

    repeat (2) begin
      tick();
      check("hold_done", 32'(o_done), 1);
      check("hold_err",  32'(o_err), 32'(errs));
      check("hold_fail", 32'(o_fail), 32'(diff));
      check("hold_xy",   32'({o_x, o_y}), 3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    sel       = 1'b0;
    gate_tt_a = 4'b1000;
    gate_tt_b = 4'b0110;
    tick();
    tick();
    sel = 1'b0; check_all_zero("reset_a");
    sel = 1'b1; check_all_zero("reset_b");
    sel = 1'b0;
    rst = 1'b0;
    tick();

    // Default AND table: ideal AND, stuck-at-0, OR, start noise while busy.
    run_check(4'b1000, 1'b0);
    run_check(4'b0000, 1'b0);
    run_check(4'b1110, 1'b0);
    run_check(4'b1000, 1'b1);
    run_check(4'b0110, 1'b1);

    // Reset out of DONE after a failing run clears the result.
    run_check(4'b0000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst_done");

    // Reset at cycle 5 of a run, while vector 01 is applied.
    gate_tt_a = 4'b1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("mid_xy", 32'({o_x, o_y}), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst_mid");
    run_check(4'b1000, 1'b0);

    repeat (20) run_check(4'($urandom), 1'($urandom_range(0, 1)));

    // XOR table with single settle cycle.
    sel = 1'b1;
    run_check(4'b0110, 1'b0);
    run_check(4'b1000, 1'b0);
    repeat (10) run_check(4'($urandom), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
